// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Op codes, FSM states and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// ID/EX to muldiv bundle: op request, MT/MF controls, flush,
// and the unit's busy/stall/done status plus HI/LO values.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic             hilo_read;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    output hi_we, lo_we, hilo_read, flush,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    input  hi_we, lo_we, hilo_read, flush,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc_i/acc_o = {upper, lower}; opnd_i = multiplicand or divisor.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH:0] shl;
  logic             ge;
  logic [WIDTH-1:0] rem;

  always_comb begin
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
            + {1'b0, opnd_i};
    shl     = {acc_i, 1'b0};
    // shifted remainder may carry into bit WIDTH;
    // the modular difference is exact when ge holds
    ge      = shl[2*WIDTH:WIDTH] >= {1'b0, opnd_i};
    rem     = shl[2*WIDTH-1:WIDTH] - opnd_i;
    acc_o   = '0;
    if (is_div_i) begin
      if (ge) begin
        acc_o = {rem, shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_o = shl[2*WIDTH-1:0];
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {add_sum, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, MTHI/MTLO and stall.
// Ports: clock, reset (sync, active-high), bus (muldiv_if.slave).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITER,
  parameter int CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  muldiv_if.slave bus
);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic               sa_q, sa_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_step;
  logic               sgn_in;
  logic               a_neg, b_neg;
  logic               div_in;
  logic               start_ok;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (op_q[1]),
    .acc_o    (acc_step)
  );

  always_comb begin
    sgn_in   = md_is_signed(bus.op);
    div_in   = bus.op[1];
    a_neg    = sgn_in & bus.operand_a[WIDTH-1];
    b_neg    = sgn_in & bus.operand_b[WIDTH-1];
    abs_a    = a_neg ? -bus.operand_a : bus.operand_a;
    abs_b    = b_neg ? -bus.operand_b : bus.operand_b;
    start_ok = (state_q == ST_IDLE)
             & bus.start & ~bus.flush;
    prod     = neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rmd      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          op_d    = md_op_e'(bus.op);
          sa_d    = a_neg;
          neg_d   = a_neg ^ b_neg;
          dz_d    = div_in & (bus.operand_b == '0);
          cnt_d   = '0;
          // divide iterates on the dividend,
          // multiply on the multiplier
          acc_d   = div_in ? {{WIDTH{1'b0}}, abs_a}
                           : {{WIDTH{1'b0}}, abs_b};
          opnd_d  = div_in ? abs_b : abs_a;
          state_d = ST_RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.operand_a;
          if (bus.lo_we) lo_d = bus.operand_a;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        unique case (op_q)
          MD_MULT, MD_MULTU: begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          MD_DIV, MD_DIVU: begin
            // remainder follows the dividend sign,
            // which also restores operand_a on /0
            hi_d = sa_q ? -rmd : rmd;
            lo_d = dz_q  ? '1
                 : neg_q ? -quo : quo;
          end
          default: ;
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULT;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.stall_req = bus.busy
                       & (bus.start | bus.hilo_read
                       | bus.hi_we | bus.lo_we);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage; consumes the ALU control, operands and valid from the ID/EX pipeline register outputs.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over 34 cycles; also services MTHI/MTLO writes and MFHI/MFLO reads.
- While busy, requests a pipeline stall from the hazard logic so that IF/ID and ID/EX hold their contents.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  valid muldiv op presented this cycle from ID/EX.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data).
- operand_b  in  WIDTH  rt value (multiplier/divisor).
- hi_we  in  1  MTHI request.
- lo_we  in  1  MTLO request.
- hilo_read  in  1  EX instruction is MFHI/MFLO.
- flush  in  1  abort the in-flight op (branch/exception squash).
- busy  out  1  operation in progress.
- stall_req  out  1  hold ID/EX and earlier stages.
- done  out  1  one-cycle pulse when HI/LO are updated by an op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset overrides every other input, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE with start=1 at edge k:
  - Latch op.
  - For signed ops, latch |operand_a| and |operand_b| and the sign flags.
  - Clear the accumulator, counter=0, next state RUN.
- RUN, edges k+1..k+32: one radix-2 step per edge.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - Counter increments each step; after the 32nd step, next state FIX.
- FIX, edge k+33:
  - Apply sign correction and write HI/LO.
  - Pulse done=1 for the cycle following edge k+33; return to IDLE.
  - New HI/LO values are visible in that same cycle.
- busy: high from the cycle after edge k through the cycle before done; low in the done cycle.
- stall_req = busy & (start | hilo_read | hi_we | lo_we). Combinational, no latency.
- Sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient (LO) is negated if the signs differ; remainder (HI) takes the dividend's sign.
  - Unsigned ops: no correction.
- Arithmetic and width:
  - Absolute values are computed in WIDTH bits, so -2^31 maps to 0x80000000 unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=operand_a as originally presented. Takes the full latency; no exception.
- MTHI/MTLO when not busy: hi/lo <= operand_a at the next edge.
  - Simultaneous hi_we and start in IDLE: the op is accepted, and the MT write is dropped in favour of the op result.
  - hi_we or lo_we while busy: ignored; stall_req holds the instruction until the unit is idle.
- start while busy: ignored. The stall guarantees it is re-presented later.
- flush: in RUN or FIX, next state IDLE at the next edge; HI/LO unchanged, no done pulse. flush with start in IDLE: start is ignored. flush takes priority over start.
- hilo_read in IDLE, or in the done cycle: no stall; hi/lo are read directly.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encodings ST_IDLE, ST_RUN, ST_FIX;
  - constant MD_ITER=32.
- One natural sub-module: muldiv_step, purely combinational, one shift-add or shift-subtract iteration (inputs: accumulator, operand, mode; output: next accumulator). It is instantiated once; the top level holds the FSM, counter, sign fixup and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge k -> done pulse after edge k+33; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064 after full latency. Follow with MTLO 0x1234 in idle -> lo=0x00001234 next cycle.
- Start DIVU, assert hilo_read at RUN step 5 -> stall_req=1 until the done cycle. Then flush a second op at step 10 -> busy=0 next cycle, no done, HI/LO retain the first result.
- Assert reset at RUN step 20 -> next cycle busy=0, done=0, hi=0, lo=0. A start one cycle after reset is accepted normally.
